// File: rtl/nn_mult_pkg.sv
// Shared definitions for the neuron-layer multiplier server and its arbiter.
package nn_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANTED = 3'd1,
        ST_BUSY    = 3'd2,
        ST_DONE    = 3'd3,
        ST_HOLD    = 3'd4
    } st_mult_server_e;

    // Owner index width; a single client still needs one bit to index with.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin pick: first requesting client at or after the pointer, wrapping.
module mult_rr_arbiter
    import nn_mult_pkg::*;
#(
    parameter int NumClients = 5,
    parameter int IdxW       = idx_w(NumClients)
) (
    input  logic [NumClients-1:0] req_i,
    input  logic [IdxW-1:0]       ptr_i,
    output logic [IdxW-1:0]       owner_o,
    output logic                  found_o
);

    logic [IdxW-1:0] cand;

    // Walk offsets from far to near so the closest requester is written last.
    always_comb begin
        owner_o = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int off = NumClients - 1; off >= 0; off--) begin
            cand = IdxW'((int'(ptr_i) + off) % NumClients);
            if (req_i[cand]) begin
                owner_o = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mult_server.sv
// Shared sequential multiplier: round-robin req/grant mutex, shift-add engine,
// one-cycle done pulse to the owner, grant held until the owner drops req.
module shared_mult_server
    import nn_mult_pkg::*;
#(
    parameter int NumClients = 5,
    parameter int DataWidth  = 8,
    parameter int Signed     = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NumClients-1:0]           mult_req_i,
    output logic [NumClients-1:0]           mult_grant_o,
    input  logic [NumClients-1:0]           mult_start_i,
    input  logic [NumClients*DataWidth-1:0] mult_a_i,
    input  logic [NumClients*DataWidth-1:0] mult_b_i,
    output logic                            mult_busy_o,
    output logic [NumClients-1:0]           mult_done_o,
    output logic [2*DataWidth-1:0]          mult_result_o
);

    localparam int IdxW = idx_w(NumClients);
    localparam int CntW = $clog2(DataWidth + 1);
    localparam int ResW = 2 * DataWidth;

    // -2^(DW-1) maps to an unsigned DW-bit magnitude of 2^(DW-1).
    function automatic logic [DataWidth-1:0] magnitude(input logic [DataWidth-1:0] v);
        if (Signed != 0 && v[DataWidth-1]) return ~v + 1'b1;
        return v;
    endfunction

    function automatic logic [ResW-1:0] apply_sign(input logic [ResW-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    st_mult_server_e       state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [NumClients-1:0] grant_q, grant_d;
    logic [NumClients-1:0] done_q, done_d;
    logic [ResW-1:0]       result_q, result_d;
    logic [ResW-1:0]       acc_q, acc_d;
    logic [ResW-1:0]       mcand_q, mcand_d;
    logic [DataWidth-1:0]  mplier_q, mplier_d;
    logic                  sign_q, sign_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  armed_q, armed_d;

    logic [IdxW-1:0]       arb_owner;
    logic                  arb_found;
    logic                  owner_req;
    logic                  owner_start;
    logic [DataWidth-1:0]  op_a;
    logic [DataWidth-1:0]  op_b;
    logic [ResW-1:0]       acc_step;
    logic [IdxW-1:0]       ptr_next;

    mult_rr_arbiter #(
        .NumClients(NumClients),
        .IdxW      (IdxW)
    ) u_arb (
        .req_i  (mult_req_i),
        .ptr_i  (ptr_q),
        .owner_o(arb_owner),
        .found_o(arb_found)
    );

    assign owner_req   = mult_req_i[owner_q];
    assign owner_start = mult_start_i[owner_q];
    assign op_a        = mult_a_i[owner_q*DataWidth +: DataWidth];
    assign op_b        = mult_b_i[owner_q*DataWidth +: DataWidth];
    assign acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign ptr_next    = (owner_q == IdxW'(NumClients - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;

        // A held start must be seen low before the owner may chain another.
        if (!owner_start) armed_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    owner_d          = arb_owner;
                    grant_d          = '0;
                    grant_d[arb_owner] = 1'b1;
                    state_d          = ST_GRANTED;
                end
            end
            ST_GRANTED, ST_HOLD: begin
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else if (owner_start && (state_q == ST_GRANTED || armed_q)) begin
                    mcand_d  = {{DataWidth{1'b0}}, magnitude(op_a)};
                    mplier_d = magnitude(op_b);
                    sign_d   = (Signed != 0) ? (op_a[DataWidth-1] ^ op_b[DataWidth-1]) : 1'b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    armed_d  = 1'b0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DataWidth - 1)) begin
                        result_d        = apply_sign(acc_step, sign_q);
                        done_d[owner_q] = 1'b1;
                        state_d         = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
        end
    end

    assign mult_grant_o  = grant_q;
    assign mult_done_o   = done_q;
    assign mult_busy_o   = (state_q == ST_BUSY);
    assign mult_result_o = result_q;

endmodule

// File: tb/tb_shared_mult_server.sv
// Scoreboard bench for shared_mult_server: 5-client signed instance plus a
// single-client unsigned instance.
module tb_shared_mult_server;

    localparam int NC = 5;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [NC-1:0]   req, start, grant, done;
    logic [NC*DW-1:0] a_bus, b_bus;
    logic            busy;
    logic [2*DW-1:0] result;

    logic            u_req, u_start, u_grant, u_done, u_busy;
    logic [DW-1:0]   u_a, u_b;
    logic [2*DW-1:0] u_result;

    typedef struct {
        int              owner;
        logic [2*DW-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    shared_mult_server #(.NumClients(NC), .DataWidth(DW), .Signed(1)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .mult_req_i   (req),
        .mult_grant_o (grant),
        .mult_start_i (start),
        .mult_a_i     (a_bus),
        .mult_b_i     (b_bus),
        .mult_busy_o  (busy),
        .mult_done_o  (done),
        .mult_result_o(result)
    );

    shared_mult_server #(.NumClients(1), .DataWidth(DW), .Signed(0)) dut_u (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .mult_req_i   (u_req),
        .mult_grant_o (u_grant),
        .mult_start_i (u_start),
        .mult_a_i     (u_a),
        .mult_b_i     (u_b),
        .mult_busy_o  (u_busy),
        .mult_done_o  (u_done),
        .mult_result_o(u_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW-1:0]   sa;
        logic signed [DW-1:0]   sb_v;
        logic signed [2*DW-1:0] p;
        sa   = a;
        sb_v = b;
        p    = sa * sb_v;
        return p;
    endfunction

    // Every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (!reset_i && done != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_owner", 32'(done), 32'(1) << e.owner);
                check("result", 32'(result), 32'(e.res));
            end
        end
    end

    // Starting at a negedge with req[c] high: wait for grant, start, track to done.
    task automatic do_op(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit hold_start);
        int  n;
        int  busy_n;
        bit  got;
        exp_t e;
        req[c] = 1'b1;
        n = 0;
        while (grant[c] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", 32'(grant[c]), 32'd1);
        a_bus[c*DW +: DW] = a;
        b_bus[c*DW +: DW] = b;
        start[c] = 1'b1;
        e.owner = c;
        e.res   = model(a, b);
        sb.push_back(e);
        busy_n = 0;
        got    = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (k == 1) a_bus[c*DW +: DW] = ~a;
            if (k == 1 && !hold_start) start[c] = 1'b0;
            if (k == 2) start[c] = 1'b0;
            if (done[c]) begin
                got = 1'b1;
                check("done_latency", 32'(k), 32'(DW + 1));
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'(DW));
        @(negedge clk);
        check("hold_no_busy", 32'(busy), 32'd0);
        check("hold_grant", 32'(grant), 32'(1) << c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        reset_i = 1'b1;
        req = '0; start = '0; a_bus = '0; b_bus = '0;
        u_req = 1'b0; u_start = 1'b0; u_a = '0; u_b = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Client 0: grant one cycle after req, then chained operations under one grant.
        req[0] = 1'b1;
        @(negedge clk);
        check("grant0_lat", 32'(grant), 32'h1);
        do_op(0, 8'd3, 8'd5, 1'b1);
        check("res_3x5", 32'(result), 32'h000F);
        do_op(0, 8'd7, 8'hFE, 1'b0);
        check("res_7xm2", 32'(result), 32'hFFF2);
        do_op(0, 8'h00, 8'h80, 1'b0);
        do_op(0, 8'h80, 8'h80, 1'b0);
        check("res_min_sq", 32'(result), 32'h4000);
        do_op(0, 8'hFF, 8'h7F, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);
        check("rel0_grant", 32'(grant), 32'd0);

        // Client 1 granted, drops req without starting.
        req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("grant1", 32'(grant), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);
        check("drop1_grant", 32'(grant), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | busy | (done != '0);
        end
        check("drop1_quiet", 32'(seen), 32'd0);

        // Client 3 start, async reset asserted in the 4th BUSY cycle.
        req[3] = 1'b1;
        n = 0;
        while (grant[3] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant3", 32'(grant), 32'h8);
        a_bus[3*DW +: DW] = 8'd9;
        b_bus[3*DW +: DW] = 8'd11;
        start[3] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start[3] = 1'b0;
        end
        check("busy_before_rst", 32'(busy), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        sb.delete();
        req = '0;
        start = '0;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        // Pointer at 0 after reset: clients 0 and 2 request together.
        req[0] = 1'b1;
        req[2] = 1'b1;
        @(negedge clk);
        check("arb_first", 32'(grant), 32'h1);
        do_op(0, 8'h12, 8'h34, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);
        check("handoff_idle", 32'(grant), 32'd0);
        @(negedge clk);
        check("handoff_grant2", 32'(grant), 32'h4);
        req[0] = 1'b1;
        do_op(2, 8'hF6, 8'h0C, 1'b0);
        req[2] = 1'b0;
        @(negedge clk);
        check("wrap_idle", 32'(grant), 32'd0);
        @(negedge clk);
        check("wrap_grant0", 32'(grant), 32'h1);
        do_op(0, 8'h81, 8'h02, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);
        check("final_release", 32'(grant), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Unsigned single-client instance.
        u_req = 1'b1;
        n = 0;
        while (u_grant !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("u_grant", 32'(u_grant), 32'd1);
        u_a = 8'hFF;
        u_b = 8'hFF;
        u_start = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            u_start = 1'b0;
            if (u_done) begin
                seen = 1'b1;
                check("u_latency", 32'(k), 32'(DW + 1));
                break;
            end
        end
        check("u_done_seen", 32'(seen), 32'd1);
        check("u_result", 32'(u_result), 32'hFE01);
        u_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
